pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MDU_CYCLES, default 8: total EX-stage cycles a multiply/divide occupies; legal range 2..64.
REQ-002 Parameter REG_ADDR_W, default 5: register-address width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising clk edge.
REQ-005 id_rs  input  REG_ADDR_W  source register 1 of the instruction in ID.
REQ-006 id_rt  input  REG_ADDR_W  source register 2 of the instruction in ID.
REQ-007 id_uses_rt  input  1  the ID instruction reads id_rt.
REQ-008 ex_mem_read  input  1  the instruction in EX is a load.
REQ-009 ex_rd  input  REG_ADDR_W  destination register of the EX instruction.
REQ-010 ex_branch_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-011 ex_mdu_start  input  1  a multiply/divide entered EX this cycle.
REQ-012 stall_pc  output  1  1 = PC holds its value.
REQ-013 stall_if_id  output  1  1 = IF_ID holds (drives IF_ID en input; high = hold).
REQ-014 flush_if_id  output  1  1 = IF_ID clears to bubble on the next edge.
REQ-015 stall_id_ex  output  1  1 = ID_EX holds.
REQ-016 flush_id_ex  output  1  1 = ID_EX clears to bubble.
REQ-017 flush_ex_mem  output  1  1 = EX_MEM loads a bubble.
REQ-018 mdu_busy  output  1  registered; 1 while the FSM is in MDU_BUSY.

Function
REQ-019 FSM states: RUN (2'b00), MDU_BUSY (2'b01); no other reachable state; an illegal encoding returns to RUN on the next edge.
REQ-020 Down-counter mdu_cnt, width ceil(log2(MDU_CYCLES)).
REQ-021 Load-use hazard lu = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)).
REQ-022 RUN, ex_branch_taken=1: flush_if_id=1, flush_id_ex=1, all stalls 0; lu is ignored that cycle.
REQ-023 RUN, lu=1, no branch: stall_pc=1, stall_if_id=1, flush_id_ex=1, all other outputs 0; exactly one bubble per hazard, because the load leaves EX on the next edge.
REQ-024 RUN, ex_mdu_start=1: on the next edge go to MDU_BUSY and load mdu_cnt=MDU_CYCLES-2.
REQ-025 RUN, ex_mdu_start=1: outputs this cycle are per REQ-022/023; the MDU op itself completes its first cycle.
REQ-026 MDU_BUSY: stall_pc=stall_if_id=stall_id_ex=1 and flush_ex_mem=1; flush_if_id=flush_id_ex=0.
REQ-027 MDU_BUSY: lu, ex_branch_taken and ex_mdu_start are ignored.
REQ-028 MDU_BUSY, mdu_cnt!=0: decrement by 1 each cycle.
REQ-029 MDU_BUSY, mdu_cnt==0: stalls remain asserted this cycle; return to RUN on the next edge.
REQ-030 Total pipeline freeze per MDU op is exactly MDU_CYCLES-1 cycles, counted after the start cycle.
REQ-031 A stall and a flush of the same register are never both 1 in any cycle.
REQ-032 All outputs except mdu_busy are combinational from inputs and state; there are no latches.

Reset
REQ-033 rst=1 at an edge: state=RUN, mdu_cnt=0, mdu_busy=0; this overrides any in-progress MDU op, including one started in the same cycle.
REQ-034 While rst=1: all stall/flush outputs are 0 regardless of inputs.
REQ-035 First cycle after rst deasserts: the FSM is in RUN and evaluates inputs normally.

Verification
REQ-036 Load-use: ex_mem_read=1, ex_rd=3, id_rs=3 for 1 cycle -> stall_pc=stall_if_id=flush_id_ex=1 that cycle, then all 0 once the inputs are removed.
REQ-037 r0 hazard: ex_mem_read=1, ex_rd=0, id_rs=0 -> no stall, no flush.
REQ-038 rt gating: ex_rd=7, id_rt=7, id_uses_rt=0 -> no stall; id_uses_rt=1 -> stall.
REQ-039 Branch with concurrent load-use: ex_branch_taken=1 and lu=1 -> flush_if_id=flush_id_ex=1, stall_pc=0.
REQ-040 MDU: MDU_CYCLES=8, ex_mdu_start pulse -> mdu_busy=1 and stall_pc=1 for exactly 7 cycles, then RUN; a branch pulse injected mid-busy produces no flush.
REQ-041 Reset mid-MDU: rst on the 3rd busy cycle -> next cycle mdu_busy=0, all outputs 0, and a new ex_mdu_start restarts the full 7-cycle count.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and
// multi-cycle multiply/divide freeze for a classic 5-stage pipeline.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; load-use stalls and branch flushes are decoded
// MDU_BUSY | mul/div still in EX; IF/ID/EX frozen, bubbles fed to MEM
module pipeline_hazard_ctrl #(
  parameter int MDU_CYCLES = 8,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mdu_start,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  stall_id_ex,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mem,
  output logic                  mdu_busy
);

  localparam int CNT_W = $clog2(MDU_CYCLES);
  // The start cycle is already the first MDU cycle, so the busy phase
  // covers counter values MDU_CYCLES-2 down to 0 inclusive.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 2);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MDU_BUSY = 2'b01
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
  logic             mdu_busy_q, mdu_busy_d;
  logic             lu;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  // State, counter and busy flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      mdu_cnt_q  <= '0;
      mdu_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mdu_cnt_q  <= mdu_cnt_d;
      mdu_busy_q <= mdu_busy_d;
    end
  end

  // Next-state decode and combinational stall/flush outputs.
  always_comb begin
    state_d      = state_q;
    mdu_cnt_d    = mdu_cnt_q;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;

    case (state_q)
      RUN: begin
        if (ex_mdu_start) begin
          state_d   = MDU_BUSY;
          mdu_cnt_d = CNT_LOAD;
        end
        // A taken branch squashes the ID instruction anyway, so a
        // concurrent load-use stall would only waste a cycle.
        if (ex_branch_taken) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (lu) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
      end
      MDU_BUSY: begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
        if (mdu_cnt_q != '0) begin
          mdu_cnt_d = mdu_cnt_q - CNT_W'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = RUN;
        mdu_cnt_d = '0;
      end
    endcase

    if (rst) begin
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      flush_if_id  = 1'b0;
      stall_id_ex  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
    end
  end

  assign mdu_busy_d = (state_d == MDU_BUSY);
  assign mdu_busy   = mdu_busy_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations plus a long randomized run against a cycle-count model.
module tb_pipeline_hazard_ctrl;

  localparam int MDU_CYCLES = 8;
  localparam int REG_ADDR_W = 5;

  logic                  clk;
  logic                  rst;
  logic [REG_ADDR_W-1:0] id_rs, id_rt, ex_rd;
  logic                  id_uses_rt, ex_mem_read, ex_branch_taken, ex_mdu_start;
  logic                  stall_pc, stall_if_id, flush_if_id, stall_id_ex;
  logic                  flush_id_ex, flush_ex_mem, mdu_busy;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: number of frozen cycles still ahead, as seen in the current cycle.
  int freeze_left = 0;
  bit model_ok = 1'b0;

  pipeline_hazard_ctrl #(
    .MDU_CYCLES(MDU_CYCLES),
    .REG_ADDR_W(REG_ADDR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .ex_mdu_start   (ex_mdu_start),
    .stall_pc       (stall_pc),
    .stall_if_id    (stall_if_id),
    .flush_if_id    (flush_if_id),
    .stall_id_ex    (stall_id_ex),
    .flush_id_ex    (flush_id_ex),
    .flush_ex_mem   (flush_ex_mem),
    .mdu_busy       (mdu_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, flush_ex_mem, mdu_busy}
  function automatic logic [6:0] outs();
    return {stall_pc, stall_if_id, flush_if_id, stall_id_ex,
            flush_id_ex, flush_ex_mem, mdu_busy};
  endfunction

  function automatic logic [6:0] model_expect();
    logic hazard;
    logic busy;
    busy   = (freeze_left > 0);
    hazard = ex_mem_read && (ex_rd != 0) &&
             (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
    if (rst)             return {6'b000000, busy};
    if (busy)            return 7'b1101011;
    if (ex_branch_taken) return 7'b0010100;
    if (hazard)          return 7'b1100100;
    return 7'b0000000;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance: a start outside a freeze buys MDU_CYCLES-1 frozen cycles.
  always @(posedge clk) begin
    if (rst) begin
      freeze_left = 0;
      model_ok    = 1'b1;
    end else if (freeze_left > 0) begin
      freeze_left = freeze_left - 1;
    end else if (ex_mdu_start) begin
      freeze_left = MDU_CYCLES - 1;
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) check("model", outs(), model_expect());
  end

  task automatic set_in(input logic r, input logic mr, input int rd, input int rs,
                        input int rt, input logic uses, input logic br, input logic st);
    rst             = r;
    ex_mem_read     = mr;
    ex_rd           = REG_ADDR_W'(rd);
    id_rs           = REG_ADDR_W'(rs);
    id_rt           = REG_ADDR_W'(rt);
    id_uses_rt      = uses;
    ex_branch_taken = br;
    ex_mdu_start    = st;
  endtask

  // Drive one cycle of inputs, check a literal mid-cycle, move past the edge.
  task automatic step(input string name, input logic r, input logic mr, input int rd,
                      input int rs, input int rt, input logic uses, input logic br,
                      input logic st, input logic [6:0] exp);
    set_in(r, mr, rd, rs, rt, uses, br, st);
    @(negedge clk);
    check(name, outs(), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with every hazard source active: outputs must stay quiet.
    step("rst_quiet",     1, 1, 3, 3, 0, 0, 1, 1, 7'b0000000);
    step("rst_start",     1, 0, 0, 0, 0, 0, 0, 1, 7'b0000000);
    step("idle",          0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);
    step("load_use",      0, 1, 3, 3, 0, 0, 0, 0, 7'b1100100);
    step("load_use_gone", 0, 0, 3, 3, 0, 0, 0, 0, 7'b0000000);
    step("r0_no_hazard",  0, 1, 0, 0, 0, 0, 0, 0, 7'b0000000);
    step("rt_unused",     0, 1, 7, 1, 7, 0, 0, 0, 7'b0000000);
    step("rt_used",       0, 1, 7, 1, 7, 1, 0, 0, 7'b1100100);
    step("branch_lu",     0, 1, 3, 3, 0, 0, 1, 0, 7'b0010100);
    step("branch_only",   0, 0, 0, 0, 0, 0, 1, 0, 7'b0010100);

    // MDU op: start cycle itself is not frozen, then exactly 7 frozen cycles.
    step("mdu_start",     0, 0, 0, 0, 0, 0, 0, 1, 7'b0000000);
    for (int i = 0; i < MDU_CYCLES - 1; i++) begin
      if (i == 3) step("mdu_busy_branch", 0, 1, 2, 2, 0, 0, 1, 1, 7'b1101011);
      else        step("mdu_busy",        0, 0, 0, 0, 0, 0, 0, 0, 7'b1101011);
    end
    step("mdu_done",      0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);

    // Reset on the 3rd busy cycle, then a fresh op runs its full length.
    step("mdu2_start",    0, 0, 0, 0, 0, 0, 0, 1, 7'b0000000);
    step("mdu2_busy1",    0, 0, 0, 0, 0, 0, 0, 0, 7'b1101011);
    step("mdu2_busy2",    0, 0, 0, 0, 0, 0, 0, 0, 7'b1101011);
    step("mdu2_rst",      1, 0, 0, 0, 0, 0, 0, 0, 7'b0000001);
    step("post_rst",      0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);
    step("mdu3_start",    0, 0, 0, 0, 0, 0, 0, 1, 7'b0000000);
    for (int i = 0; i < MDU_CYCLES - 1; i++)
      step("mdu3_busy",   0, 0, 0, 0, 0, 0, 0, 0, 7'b1101011);
    step("mdu3_done",     0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);

    // Randomized traffic with small register numbers so hazards are frequent.
    for (int i = 0; i < 4000; i++) begin
      set_in(($urandom_range(0, 79) == 0),
             logic'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)),
             logic'($urandom_range(0, 1)),
             ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 11) == 0));
      @(posedge clk);
      #1;
    end

    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
